// File: rtl/hdlc_check_pkg.sv
// Shared types and constants for the HDLC line checker.
package hdlc_check_pkg;

  localparam int NUM_RULES = 3;
  localparam int MAX_VIOL  = 48;

  typedef enum logic [1:0] {
    RULE_FLAG  = 2'd0,
    RULE_ABORT = 2'd1,
    RULE_IDLE  = 2'd2
  } rule_e;

  typedef enum logic [1:0] {
    TX_FRAME = 2'd0,
    TX_GAP   = 2'd1,
    TX_IDLE  = 2'd2
  } tx_state_t;

  localparam logic [7:0] FLAG_PATTERN = 8'b0111_1110;

  function automatic logic [5:0] popcount48(input logic [MAX_VIOL-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < MAX_VIOL; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hdlc_chan_checker.sv
// Per-channel rule evaluation: flag latency, abort response and Tx idle fill.
// o_viol is combinational and reports violations due in the current cycle.
module hdlc_chan_checker
  import hdlc_check_pkg::*;
#(
  parameter int FLAG_LATENCY = 2,
  parameter int IDLE_BITS    = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_rx,
  input  logic       i_flag_detect,
  input  logic       i_abort_detect,
  input  logic       i_valid_frame,
  input  logic       i_abort_signal,
  input  logic       i_tx,
  input  logic       i_tx_valid_frame,
  output logic [2:0] o_viol
);

  localparam int GAP_W = $clog2(IDLE_BITS + 1);

  logic [7:0]              r_hist;
  logic [3:0]              r_fill;
  logic [FLAG_LATENCY-1:0] r_exp;
  logic                    r_abort_due;
  tx_state_t               r_tx_state;
  tx_state_t               w_tx_state_nxt;
  logic [GAP_W-1:0]        r_gap_cnt;
  logic [GAP_W-1:0]        w_gap_cnt_nxt;
  logic [7:0]              w_hist_nxt;
  logic                    w_match;
  logic                    w_idle_viol;

  // The match cycle is the one sampling the 8th bit, so 7 prior bits suffice.
  assign w_hist_nxt = {r_hist[6:0], i_rx};
  assign w_match    = (r_fill >= 4'd7) && (w_hist_nxt == FLAG_PATTERN);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_hist      <= 8'd0;
      r_fill      <= 4'd0;
      r_exp       <= '0;
      r_abort_due <= 1'b0;
    end else begin
      r_hist      <= w_hist_nxt;
      r_fill      <= (r_fill == 4'd8) ? r_fill : r_fill + 4'd1;
      r_exp[0]    <= w_match;
      for (int i = 1; i < FLAG_LATENCY; i++) begin
        r_exp[i] <= r_exp[i-1];
      end
      r_abort_due <= i_abort_detect & i_valid_frame;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_tx_state <= TX_GAP;
      r_gap_cnt  <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_gap_cnt_nxt  = r_gap_cnt;
    if (i_tx_valid_frame) begin
      w_tx_state_nxt = TX_FRAME;
      w_gap_cnt_nxt  = '0;
    end else begin
      case (r_tx_state)
        TX_FRAME, TX_GAP: begin
          w_gap_cnt_nxt  = r_gap_cnt + GAP_W'(1);
          w_tx_state_nxt = (w_gap_cnt_nxt == GAP_W'(IDLE_BITS)) ? TX_IDLE : TX_GAP;
        end
        TX_IDLE: begin
          w_tx_state_nxt = TX_IDLE;
        end
        default: begin
          w_tx_state_nxt = TX_GAP;
          w_gap_cnt_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_idle_viol = (r_tx_state == TX_IDLE) && !i_tx;
  end

  assign o_viol = {w_idle_viol,
                   r_abort_due & ~i_abort_signal,
                   r_exp[FLAG_LATENCY-1] & ~i_flag_detect};

endmodule

// File: rtl/hdlc_line_checker.sv
// Multi-channel HDLC protocol checker: sticky flags, saturating error count
// and first-error capture over the per-channel rule checkers.
module hdlc_line_checker
  import hdlc_check_pkg::*;
#(
  parameter int CHANNELS     = 1,
  parameter int FLAG_LATENCY = 2,
  parameter int IDLE_BITS    = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Enable,
  input  logic                    ErrClear,
  input  logic [CHANNELS-1:0]     Rx,
  input  logic [CHANNELS-1:0]     Rx_FlagDetect,
  input  logic [CHANNELS-1:0]     Rx_AbortDetect,
  input  logic [CHANNELS-1:0]     Rx_ValidFrame,
  input  logic [CHANNELS-1:0]     Rx_AbortSignal,
  input  logic [CHANNELS-1:0]     Tx,
  input  logic [CHANNELS-1:0]     Tx_ValidFrame,
  output logic [3*CHANNELS-1:0]   ErrFlags,
  output logic [CNT_WIDTH-1:0]    ErrCnt,
  output logic                    FirstErrValid,
  output logic [3:0]              FirstErrChan,
  output logic [1:0]              FirstErrRule
);

  localparam int                   SUM_W   = CNT_WIDTH + 7;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [3*CHANNELS-1:0] w_viol;
  logic [3*CHANNELS-1:0] w_viol_en;
  logic [5:0]            w_pop;
  logic [SUM_W-1:0]      w_sum;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_first_hit;
  logic [3:0]            w_first_chan;
  logic [1:0]            w_first_rule;

  logic [3*CHANNELS-1:0] r_err_flags;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic                  r_first_valid;
  logic [3:0]            r_first_chan;
  logic [1:0]            r_first_rule;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    hdlc_chan_checker #(
      .FLAG_LATENCY (FLAG_LATENCY),
      .IDLE_BITS    (IDLE_BITS)
    ) u_chan (
      .Clk              (Clk),
      .Rst              (Rst),
      .i_rx             (Rx[c]),
      .i_flag_detect    (Rx_FlagDetect[c]),
      .i_abort_detect   (Rx_AbortDetect[c]),
      .i_valid_frame    (Rx_ValidFrame[c]),
      .i_abort_signal   (Rx_AbortSignal[c]),
      .i_tx             (Tx[c]),
      .i_tx_valid_frame (Tx_ValidFrame[c]),
      .o_viol           (w_viol[3*c +: 3])
    );
  end

  always_comb begin
    w_viol_en = Enable ? w_viol : '0;
    w_pop     = popcount48(MAX_VIOL'(w_viol_en));
    w_sum     = SUM_W'(r_err_cnt) + SUM_W'(w_pop);
    w_cnt_nxt = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_WIDTH-1:0];
  end

  // Scan from the top down so the lowest channel, then lowest rule, is left standing.
  always_comb begin
    w_first_hit  = |w_viol_en;
    w_first_chan = 4'd0;
    w_first_rule = 2'd0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
        w_first_chan = w_viol_en[3*c+r] ? 4'(c) : w_first_chan;
        w_first_rule = w_viol_en[3*c+r] ? 2'(r) : w_first_rule;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_err_flags   <= '0;
      r_err_cnt     <= '0;
      r_first_valid <= 1'b0;
      r_first_chan  <= 4'd0;
      r_first_rule  <= 2'd0;
    end else if (ErrClear) begin
      r_err_flags   <= '0;
      r_err_cnt     <= '0;
      r_first_valid <= 1'b0;
      r_first_chan  <= 4'd0;
      r_first_rule  <= 2'd0;
    end else begin
      r_err_flags <= r_err_flags | w_viol_en;
      r_err_cnt   <= w_cnt_nxt;
      if (!r_first_valid && w_first_hit) begin
        r_first_valid <= 1'b1;
        r_first_chan  <= w_first_chan;
        r_first_rule  <= w_first_rule;
      end
    end
  end

  assign ErrFlags      = r_err_flags;
  assign ErrCnt        = r_err_cnt;
  assign FirstErrValid = r_first_valid;
  assign FirstErrChan  = r_first_chan;
  assign FirstErrRule  = r_first_rule;

endmodule

// File: tb/tb_hdlc_line_checker.sv
// Directed bench for hdlc_line_checker: 4 channels, 4-bit counter.
module tb_hdlc_line_checker;

  localparam int CH = 4;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Enable;
  logic          ErrClear;
  logic [CH-1:0] Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal;
  logic [CH-1:0] Tx, Tx_ValidFrame;
  logic [3*CH-1:0] ErrFlags;
  logic [CW-1:0]   ErrCnt;
  logic            FirstErrValid;
  logic [3:0]      FirstErrChan;
  logic [1:0]      FirstErrRule;

  int vectors = 0;
  int miscompares = 0;

  hdlc_line_checker #(
    .CHANNELS     (CH),
    .FLAG_LATENCY (2),
    .IDLE_BITS    (8),
    .CNT_WIDTH    (CW)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Enable         (Enable),
    .ErrClear       (ErrClear),
    .Rx             (Rx),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_AbortSignal (Rx_AbortSignal),
    .Tx             (Tx),
    .Tx_ValidFrame  (Tx_ValidFrame),
    .ErrFlags       (ErrFlags),
    .ErrCnt         (ErrCnt),
    .FirstErrValid  (FirstErrValid),
    .FirstErrChan   (FirstErrChan),
    .FirstErrRule   (FirstErrRule)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_errs();
    ErrClear = 1'b1;
    tick();
    ErrClear = 1'b0;
  endtask

  // Bits are sent oldest first from bits[7] downward on channel 0.
  task automatic send_rx0(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      Rx[0] = bits[7-i];
      tick();
    end
    Rx[0] = 1'b0;
  endtask

  task automatic run_gap(input int zero_at);
    Tx_ValidFrame[0] = 1'b1;
    tick();
    Tx_ValidFrame[0] = 1'b0;
    for (int g = 1; g <= 12; g++) begin
      Tx[0] = (g == zero_at) ? 1'b0 : 1'b1;
      tick();
    end
    Tx[0] = 1'b1;
  endtask

  initial begin
    Rst = 1'b1; Enable = 1'b1; ErrClear = 1'b0;
    Rx = '0; Rx_FlagDetect = '0; Rx_AbortDetect = '0; Rx_ValidFrame = '0;
    Rx_AbortSignal = '0; Tx = '1; Tx_ValidFrame = '0;
    #2;
    chk("rst_flags", 32'(ErrFlags), 32'h0);
    chk("rst_cnt", 32'(ErrCnt), 32'h0);
    chk("rst_fvalid", 32'(FirstErrValid), 32'h0);
    chk("rst_fchan", 32'(FirstErrChan), 32'h0);
    chk("rst_frule", 32'(FirstErrRule), 32'h0);
    tick(); tick();
    Rst = 1'b0;

    // Only 7 bits since reset: pattern present but history not yet valid
    send_rx0(8'b1111_1100, 7);
    tick(); tick();
    chk("fill_nomatch", 32'(ErrFlags), 32'h0);

    send_rx0(8'b0111_1110, 8);
    tick();
    Rx_FlagDetect[0] = 1'b1; tick(); Rx_FlagDetect[0] = 1'b0;
    chk("flag_ok_flags", 32'(ErrFlags), 32'h0);
    chk("flag_ok_cnt", 32'(ErrCnt), 32'h0);

    send_rx0(8'b0111_1110, 8);
    tick();
    chk("flag_late_pre", 32'(ErrFlags), 32'h0);
    tick();
    chk("flag_late_flags", 32'(ErrFlags), 32'h001);
    chk("flag_late_cnt", 32'(ErrCnt), 32'h1);
    chk("flag_late_fvalid", 32'(FirstErrValid), 32'h1);
    chk("flag_late_frule", 32'(FirstErrRule), 32'h0);
    Rx_FlagDetect[0] = 1'b1; tick(); Rx_FlagDetect[0] = 1'b0;
    chk("flag_late_after", 32'(ErrCnt), 32'h1);
    clear_errs();
    chk("clr_cnt", 32'(ErrCnt), 32'h0);
    chk("clr_fvalid", 32'(FirstErrValid), 32'h0);

    Rx_ValidFrame[0] = 1'b1; Rx_AbortDetect[0] = 1'b1; tick();
    Rx_AbortDetect[0] = 1'b0;
    chk("abort_pre", 32'(ErrFlags), 32'h0);
    tick();
    Rx_ValidFrame[0] = 1'b0;
    chk("abort_flags", 32'(ErrFlags), 32'h002);
    chk("abort_frule", 32'(FirstErrRule), 32'h1);
    clear_errs();
    Rx_AbortDetect[0] = 1'b1; tick(); Rx_AbortDetect[0] = 1'b0; tick(); tick();
    chk("abort_novalid", 32'(ErrFlags), 32'h0);
    Rx_ValidFrame[0] = 1'b1; Rx_AbortDetect[0] = 1'b1; tick();
    Rx_AbortDetect[0] = 1'b0; Rx_AbortSignal[0] = 1'b1; tick();
    Rx_AbortSignal[0] = 1'b0; Rx_ValidFrame[0] = 1'b0;
    chk("abort_answered", 32'(ErrFlags), 32'h0);

    run_gap(10);
    chk("idle10_cnt", 32'(ErrCnt), 32'h1);
    chk("idle10_flags", 32'(ErrFlags), 32'h004);
    clear_errs();
    run_gap(5);
    chk("idle5_cnt", 32'(ErrCnt), 32'h0);
    run_gap(8);
    chk("idle8_cnt", 32'(ErrCnt), 32'h0);
    run_gap(9);
    chk("idle9_cnt", 32'(ErrCnt), 32'h1);
    clear_errs();

    Rx_ValidFrame = 4'b0110; Rx_AbortDetect = 4'b0110; tick();
    Rx_AbortDetect = '0; tick(); Rx_ValidFrame = '0;
    chk("multi_cnt", 32'(ErrCnt), 32'h2);
    chk("multi_fchan", 32'(FirstErrChan), 32'h1);
    chk("multi_frule", 32'(FirstErrRule), 32'h1);
    chk("multi_flags", 32'(ErrFlags), 32'h090);
    Rx_ValidFrame = 4'b0001; Rx_AbortDetect = 4'b0001; tick();
    Rx_AbortDetect = '0; tick(); Rx_ValidFrame = '0;
    chk("multi2_cnt", 32'(ErrCnt), 32'h3);
    chk("multi2_fchan", 32'(FirstErrChan), 32'h1);
    chk("multi2_flags", 32'(ErrFlags), 32'h092);
    clear_errs();

    Tx = 4'b0000; tick(); tick(); tick();
    chk("sat_12", 32'(ErrCnt), 32'd12);
    Tx = 4'b1100; tick();
    chk("sat_14", 32'(ErrCnt), 32'd14);
    Tx = 4'b1000; tick();
    chk("sat_15", 32'(ErrCnt), 32'd15);
    Tx = 4'b0000; tick(); tick();
    Tx = 4'b1111;
    chk("sat_hold", 32'(ErrCnt), 32'd15);
    chk("sat_flags", 32'(ErrFlags), 32'h924);
    chk("sat_frule", 32'(FirstErrRule), 32'h2);
    ErrClear = 1'b1; Tx = 4'b0000; tick();
    ErrClear = 1'b0; Tx = 4'b1111;
    chk("clrv_flags", 32'(ErrFlags), 32'h0);
    chk("clrv_cnt", 32'(ErrCnt), 32'h0);
    chk("clrv_fvalid", 32'(FirstErrValid), 32'h0);
    chk("clrv_fchan", 32'(FirstErrChan), 32'h0);
    chk("clrv_frule", 32'(FirstErrRule), 32'h0);

    Tx[0] = 1'b0; tick(); Tx[0] = 1'b1;
    chk("prerst_cnt", 32'(ErrCnt), 32'h1);
    send_rx0(8'b0111_1000, 5);
    #2;
    Rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(ErrCnt), 32'h0);
    chk("async_rst_flags", 32'(ErrFlags), 32'h0);
    tick();
    Rst = 1'b0;
    send_rx0(8'b1100_0000, 3);
    tick(); tick();
    chk("rst_partial", 32'(ErrFlags), 32'h0);
    send_rx0(8'b0111_1110, 8);
    tick();
    Rx_FlagDetect[0] = 1'b1; tick(); Rx_FlagDetect[0] = 1'b0;
    chk("rst_flag_ok", 32'(ErrFlags), 32'h0);

    Enable = 1'b0;
    send_rx0(8'b0111_1110, 8);
    tick(); tick();
    Enable = 1'b1;
    chk("en_off_cnt", 32'(ErrCnt), 32'h0);
    Enable = 1'b0;
    send_rx0(8'b0111_1110, 8);
    tick();
    Enable = 1'b1; tick();
    chk("en_due_cnt", 32'(ErrCnt), 32'h1);
    chk("en_due_flags", 32'(ErrFlags), 32'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
